cache_ctrl: RTL and testbench

//  Direct-mapped, write-through, no-write-allocate byte cache between a CPU request port and the
//  2 KB byte-wide backing RAM. mem_rdata is combinational from mem_addr; a RAM write happens on the
//  clk edge while mem_wr=1. Controller issues line fills and write-throughs; counts hits/misses.

---
 rtl/cache_ctrl_if.sv | 31 +++
 rtl/cache_ctrl.sv | 171 +++++++++++++++++
 tb/tb_cache_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_if.sv
// CPU-side request/response and RAM-side bus of the direct-mapped byte cache controller.
// The controller takes the slave view; the CPU/RAM side takes the master view.
interface cache_ctrl_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_inv;
    logic              cpu_busy;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;
    logic [15:0]       hit_cnt;
    logic [15:0]       miss_cnt;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_inv, mem_rdata,
        output cpu_busy, cpu_ready, cpu_rdata, mem_addr, mem_din, mem_wr, hit_cnt, miss_cnt
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_inv, mem_rdata,
        input  cpu_busy, cpu_ready, cpu_rdata, mem_addr, mem_din, mem_wr, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate byte cache in front of a byte-wide RAM.
// Read misses fill a whole 4-byte line from offset 0; hits and misses are counted (saturating).
module cache_ctrl #(
    parameter int ADDR_W   = 11,
    parameter int DATA_W   = 8,
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 2
) (
    input logic          clk,
    input logic          reset,
    cache_ctrl_if.slave  bus
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << OFFSET_W;

    typedef enum logic [1:0] {IDLE, LOOKUP, FILL, WRITE} state_t;

    state_t                state_q, state_d;
    logic [LINES-1:0]      valid_q, valid_d;
    logic                  req_we_q, req_we_d;
    logic [ADDR_W-1:0]     req_addr_q, req_addr_d;
    logic [DATA_W-1:0]     req_wdata_q, req_wdata_d;
    logic                  refill_q, refill_d;
    logic [OFFSET_W-1:0]   cnt_q, cnt_d;
    logic                  cpu_ready_q, cpu_ready_d;
    logic [DATA_W-1:0]     cpu_rdata_q, cpu_rdata_d;
    logic [15:0]           hit_cnt_q, hit_cnt_d;
    logic [15:0]           miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [DATA_W-1:0]     data_q [LINES][WORDS];

    logic                  data_we;
    logic [OFFSET_W-1:0]   data_off;
    logic [DATA_W-1:0]     data_wdata;
    logic                  tag_we;

    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_din;
    logic                  mem_wr;

    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_W-1:0]    req_idx;
    logic [OFFSET_W-1:0]   req_off;
    logic                  hit;

    assign req_tag = req_addr_q[ADDR_W-1 -: TAG_W];
    assign req_idx = req_addr_q[OFFSET_W +: INDEX_W];
    assign req_off = req_addr_q[OFFSET_W-1:0];
    assign hit     = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        refill_d    = refill_q;
        cnt_d       = cnt_q;
        cpu_ready_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        data_we     = 1'b0;
        data_off    = cnt_q;
        data_wdata  = bus.mem_rdata;
        tag_we      = 1'b0;
        mem_addr    = '0;
        mem_din     = '0;
        mem_wr      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cpu_inv) begin
                    valid_d = '0;
                end else if (bus.cpu_req) begin
                    req_we_d    = bus.cpu_we;
                    req_addr_d  = bus.cpu_addr;
                    req_wdata_d = bus.cpu_wdata;
                    refill_d    = 1'b0;
                    state_d     = LOOKUP;
                end
            end
            LOOKUP: begin
                // The lookup that follows a fill is a guaranteed hit and is not counted again.
                if (!refill_q) begin
                    if (hit) hit_cnt_d  = (hit_cnt_q  == 16'hFFFF) ? hit_cnt_q  : hit_cnt_q  + 16'd1;
                    else     miss_cnt_d = (miss_cnt_q == 16'hFFFF) ? miss_cnt_q : miss_cnt_q + 16'd1;
                end
                if (req_we_q) begin
                    state_d = WRITE;
                end else if (hit) begin
                    cpu_rdata_d = data_q[req_idx][req_off];
                    cpu_ready_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = FILL;
                end
            end
            FILL: begin
                mem_addr = {req_tag, req_idx, cnt_q};
                data_we  = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    valid_d[req_idx] = 1'b1;
                    tag_we           = 1'b1;
                    refill_d         = 1'b1;
                    state_d          = LOOKUP;
                end
            end
            WRITE: begin
                mem_addr    = req_addr_q;
                mem_din     = req_wdata_q;
                mem_wr      = 1'b1;
                data_we     = hit;
                data_off    = req_off;
                data_wdata  = req_wdata_q;
                cpu_ready_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            refill_q    <= 1'b0;
            cnt_q       <= '0;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            refill_q    <= refill_d;
            cnt_q       <= cnt_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // NOTE: tag/data arrays have no reset; the valid bits alone decide whether a line is usable.
    always_ff @(posedge clk) begin
        if (data_we) data_q[req_idx][data_off] <= data_wdata;
        if (tag_we)  tag_q[req_idx]            <= req_tag;
    end

    assign bus.cpu_busy  = (state_q != IDLE);
    assign bus.cpu_ready = cpu_ready_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_din   = mem_din;
    assign bus.mem_wr    = mem_wr;
    assign bus.hit_cnt   = hit_cnt_q;
    assign bus.miss_cnt  = miss_cnt_q;
endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: RAM model preloaded mem[a]=a[7:0], scoreboard of expected
// read data and completion latency, plus checks of fill addresses, write-throughs and counters.
module tb_cache_ctrl;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cache_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    cache_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(4), .OFFSET_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [DATA_W-1:0] ram [1 << ADDR_W];
    assign bus.mem_rdata = ram[bus.mem_addr];
    always @(posedge clk) if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_din;

    typedef struct {
        logic [DATA_W-1:0] rdata;
        int                lat;
    } exp_t;

    exp_t              sb [$];
    logic [ADDR_W-1:0] fill_seen [$];
    int                wr_seen;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_din;
    logic [DATA_W-1:0] held_rdata;
    int                checks   = 0;
    int                failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one request, then watches the buses until cpu_ready; latency n means ready seen at En.
    task automatic do_req(input string tag, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] exp_rdata,
                          input int exp_lat, input int exp_fills, input int exp_wrs);
        exp_t e;
        exp_t got;
        bit   done = 0;
        e.rdata = exp_rdata;
        e.lat   = exp_lat;
        sb.push_back(e);
        fill_seen.delete();
        wr_seen = 0;
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        @(posedge clk);
        for (int n = 1; n <= 20 && !done; n++) begin
            @(negedge clk);
            bus.cpu_req = 1'b0;
            if (bus.mem_wr) begin
                wr_seen++;
                wr_addr = bus.mem_addr;
                wr_din  = bus.mem_din;
            end else if (bus.mem_addr != '0) begin
                fill_seen.push_back(bus.mem_addr);
            end
            if (bus.cpu_ready) begin
                got = sb.pop_front();
                check({tag, "_rdata"}, 32'(bus.cpu_rdata), 32'(got.rdata));
                check({tag, "_latency"}, n, got.lat);
                check({tag, "_idle_at_ready"}, 32'(bus.cpu_busy), 0);
                done = 1;
            end
        end
        if (!done) begin
            check({tag, "_ready_timeout"}, 0, 1);
            void'(sb.pop_front());
        end
        check({tag, "_fill_count"}, fill_seen.size(), exp_fills);
        for (int i = 0; i < fill_seen.size() && i < exp_fills; i++)
            check({tag, "_fill_addr"}, 32'(fill_seen[i]), 32'({addr[ADDR_W-1:2], 2'(i)}));
        check({tag, "_wr_count"}, wr_seen, exp_wrs);
        if (exp_wrs > 0 && wr_seen > 0) begin
            check({tag, "_wr_addr"}, 32'(wr_addr), 32'(addr));
            check({tag, "_wr_din"}, 32'(wr_din), 32'(wdata));
        end
        @(negedge clk);
        check({tag, "_ready_pulse"}, 32'(bus.cpu_ready), 0);
    endtask

    task automatic rd(input string tag, input logic [ADDR_W-1:0] addr, input bit miss);
        logic [DATA_W-1:0] exp_d;
        exp_d      = ram[addr];
        held_rdata = exp_d;
        do_req(tag, 1'b0, addr, '0, exp_d, miss ? 7 : 2, miss ? 4 : 0, 0);
    endtask

    task automatic wr(input string tag, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] d);
        do_req(tag, 1'b1, addr, d, held_rdata, 3, 0, 1);
    endtask

    initial begin
        for (int a = 0; a < (1 << ADDR_W); a++) ram[a] = a[7:0];
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.cpu_inv   = 1'b0;
        held_rdata    = '0;
        reset         = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_busy", 32'(bus.cpu_busy), 0);
        check("rst_ready", 32'(bus.cpu_ready), 0);
        check("rst_rdata", 32'(bus.cpu_rdata), 0);
        check("rst_mem_wr", 32'(bus.mem_wr), 0);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        check("rst_mem_din", 32'(bus.mem_din), 0);
        check("rst_hits", 32'(bus.hit_cnt), 0);
        check("rst_misses", 32'(bus.miss_cnt), 0);

        rd("rd012_miss", 11'h012, 1);
        check("miss_after_1", 32'(bus.miss_cnt), 1);
        rd("rd013_hit", 11'h013, 0);
        check("hit_after_2", 32'(bus.hit_cnt), 1);

        wr("wr013_hit", 11'h013, 8'hA5);
        check("ram013", 32'(ram[11'h013]), 32'hA5);
        rd("rd013_after_wr", 11'h013, 0);
        check("hit_after_3", 32'(bus.hit_cnt), 3);

        wr("wr7f0_miss", 11'h7F0, 8'h3C);
        check("ram7f0", 32'(ram[11'h7F0]), 32'h3C);
        check("miss_after_wr", 32'(bus.miss_cnt), 2);
        rd("rd7f0_miss", 11'h7F0, 1);
        check("miss_after_4", 32'(bus.miss_cnt), 3);

        rd("rd412_evict", 11'h412, 1);
        rd("rd012_again", 11'h012, 1);
        rd("rd011_hit", 11'h011, 0);
        check("hit_after_5", 32'(bus.hit_cnt), 4);
        check("miss_after_5", 32'(bus.miss_cnt), 5);

        @(negedge clk);
        bus.cpu_inv  = 1'b1;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 11'h012;
        @(posedge clk);
        @(negedge clk);
        check("inv_no_accept", 32'(bus.cpu_busy), 0);
        bus.cpu_inv = 1'b0;
        bus.cpu_req = 1'b0;
        rd("rd012_after_inv", 11'h012, 1);
        check("cnt_kept_by_inv", 32'(bus.hit_cnt), 4);
        check("miss_after_inv", 32'(bus.miss_cnt), 6);

        // Reset lands while the fill of line 0x020 is in progress.
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 11'h020;
        @(posedge clk);
        @(negedge clk);
        bus.cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        check("in_fill_before_rst", 32'(bus.cpu_busy), 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("midfill_rst_busy", 32'(bus.cpu_busy), 0);
        check("midfill_rst_misses", 32'(bus.miss_cnt), 0);
        rd("rd020_after_rst", 11'h020, 1);
        check("miss_after_rst", 32'(bus.miss_cnt), 1);
        check("hit_after_rst", 32'(bus.hit_cnt), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
